// File: rtl/conv_sequencer.sv
// Layer sequencer for the convolution datapath. It runs feature load and bias load,
// then loops weight load / compute / send once per output-channel pass.
module conv_sequencer #(
  parameter int OCH_PER_PASS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       conv_start,
  input  logic       abort,
  input  logic [5:0] Flen,
  input  logic [8:0] num_INCH,
  input  logic [8:0] num_OUTCH,
  input  logic       f_writedone,
  input  logic       b_writedone,
  input  logic       w_writedone,
  input  logic       rdy_to_send,
  input  logic       send_done,
  output logic [2:0] command,
  output logic [5:0] cfg_flen,
  output logic [8:0] cfg_inch,
  output logic [8:0] och_base,
  output logic [8:0] och_cnt,
  output logic       busy,
  output logic       conv_done,
  output logic       conv_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_F  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_LOAD_W  = 3'd3,
    S_COMPUTE = 3'd4,
    S_SEND    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [9:0] PASS = 10'(OCH_PER_PASS);

  state_t     state, state_next;
  logic [8:0] cfg_outch;
  logic [9:0] next_base;
  logic       more_passes;
  logic       bad_cfg;
  logic       start_ok;
  logic       abort_run;

  function automatic logic [8:0] pass_cnt(input logic [9:0] remaining);
    pass_cnt = (remaining > PASS) ? PASS[8:0] : remaining[8:0];
  endfunction

  // Pass arithmetic is done in 10 bits so the last-pass test cannot wrap.
  always_comb begin
    next_base   = {1'b0, och_base} + PASS;
    more_passes = next_base < {1'b0, cfg_outch};
    bad_cfg     = (Flen == 6'd0) || (num_INCH == 9'd0) || (num_OUTCH == 9'd0);
    start_ok    = (state == S_IDLE) && conv_start && !abort;
    abort_run   = abort && (state != S_IDLE);
  end

  always_comb begin
    state_next = state;
    if (abort_run) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start_ok) state_next = bad_cfg ? S_DONE : S_LOAD_F;
        S_LOAD_F:  if (f_writedone) state_next = S_LOAD_B;
        S_LOAD_B:  if (b_writedone) state_next = S_LOAD_W;
        S_LOAD_W:  if (w_writedone) state_next = S_COMPUTE;
        S_COMPUTE: if (rdy_to_send) state_next = S_SEND;
        S_SEND:    if (send_done) state_next = more_passes ? S_LOAD_W : S_DONE;
        S_DONE:    state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      command <= 3'd0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      command <= (state_next == S_DONE) ? 3'd0 : 3'(state_next);
      busy    <= (state_next != S_IDLE) && (state_next != S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_flen  <= 6'd0;
      cfg_inch  <= 9'd0;
      cfg_outch <= 9'd0;
      och_base  <= 9'd0;
      och_cnt   <= 9'd0;
      conv_done <= 1'b0;
      conv_err  <= 1'b0;
    end else if (start_ok) begin
      cfg_flen  <= Flen;
      cfg_inch  <= num_INCH;
      cfg_outch <= num_OUTCH;
      och_base  <= 9'd0;
      och_cnt   <= pass_cnt({1'b0, num_OUTCH});
      conv_done <= 1'b0;
      conv_err  <= bad_cfg;
    end else if (abort_run) begin
      conv_err <= 1'b1;
    end else if (state == S_SEND && send_done && more_passes) begin
      och_base <= next_base[8:0];
      och_cnt  <= pass_cnt({1'b0, cfg_outch} - next_base);
    end else if (state == S_DONE) begin
      conv_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: expected command/pass values are queued when a
// stimulus step is driven and popped and compared once the DUT has reacted.
module tb_conv_sequencer;
  localparam int P = 8;
  localparam int SG_START = 0, SG_F = 1, SG_B = 2, SG_W = 3, SG_RDY = 4, SG_SEND = 5, SG_ABORT = 6;

  logic clk = 1'b0, rst = 1'b1;
  logic conv_start = 0, abort = 0;
  logic [5:0] Flen = 0;
  logic [8:0] num_INCH = 0, num_OUTCH = 0;
  logic f_writedone = 0, b_writedone = 0, w_writedone = 0, rdy_to_send = 0, send_done = 0;
  logic [2:0] command;
  logic [5:0] cfg_flen;
  logic [8:0] cfg_inch, och_base, och_cnt;
  logic busy, conv_done, conv_err;

  typedef struct {
    logic [2:0] cmd;
    logic [8:0] base;
    logic [8:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conv_sequencer #(.OCH_PER_PASS(P)) dut (
    .clk(clk), .rst(rst), .conv_start(conv_start), .abort(abort),
    .Flen(Flen), .num_INCH(num_INCH), .num_OUTCH(num_OUTCH),
    .f_writedone(f_writedone), .b_writedone(b_writedone), .w_writedone(w_writedone),
    .rdy_to_send(rdy_to_send), .send_done(send_done),
    .command(command), .cfg_flen(cfg_flen), .cfg_inch(cfg_inch),
    .och_base(och_base), .och_cnt(och_cnt), .busy(busy),
    .conv_done(conv_done), .conv_err(conv_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic set_sig(input int sg, input logic v);
    case (sg)
      SG_START: conv_start  = v;
      SG_F:     f_writedone = v;
      SG_B:     b_writedone = v;
      SG_W:     w_writedone = v;
      SG_RDY:   rdy_to_send = v;
      SG_SEND:  send_done   = v;
      default:  abort       = v;
    endcase
  endtask

  function automatic logic [8:0] min_cnt(input int outch, input int base);
    min_cnt = 9'((outch - base) < P ? (outch - base) : P);
  endfunction

  // One-cycle pulse; the DUT must show the queued expectation right after that edge.
  task automatic do_step(input string tag, input int sg, input logic [2:0] ecmd,
                         input logic [8:0] eb, input logic [8:0] ec);
    exp_t e;
    exp_q.push_back('{cmd: ecmd, base: eb, cnt: ec});
    set_sig(sg, 1'b1);
    @(negedge clk);
    set_sig(sg, 1'b0);
    e = exp_q.pop_front();
    chk({tag, "_cmd"}, 16'(command), 16'(e.cmd));
    chk({tag, "_busy"}, 16'(busy), 16'(e.cmd != 3'd0));
    if (e.cmd != 3'd0) begin
      chk({tag, "_base"}, 16'(och_base), 16'(e.base));
      chk({tag, "_cnt"}, 16'(och_cnt), 16'(e.cnt));
    end
    $display("step %-12s cmd=%0d base=%0d cnt=%0d busy=%0d done=%0d err=%0d",
             tag, command, och_base, och_cnt, busy, conv_done, conv_err);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cmd"},   16'(command),   16'd0);
    chk({tag, "_flen"},  16'(cfg_flen),  16'd0);
    chk({tag, "_inch"},  16'(cfg_inch),  16'd0);
    chk({tag, "_base"},  16'(och_base),  16'd0);
    chk({tag, "_cnt"},   16'(och_cnt),   16'd0);
    chk({tag, "_busy"},  16'(busy),      16'd0);
    chk({tag, "_done"},  16'(conv_done), 16'd0);
    chk({tag, "_err"},   16'(conv_err),  16'd0);
  endtask

  // Runs one layer; optional strays, abort in COMPUTE of a pass, or reset in SEND of a pass.
  task automatic layer(input int flen, input int inch, input int outch,
                       input bit strays, input int abort_pass, input int rst_pass);
    int base = 0;
    int pass = 1;
    Flen = 6'(flen); num_INCH = 9'(inch); num_OUTCH = 9'(outch);
    do_step("start", SG_START, 3'd1, 9'd0, min_cnt(outch, 0));
    chk("start_done_clr", 16'(conv_done), 16'd0);
    chk("start_err_clr", 16'(conv_err), 16'd0);
    chk("cfg_flen", 16'(cfg_flen), 16'(flen));
    chk("cfg_inch", 16'(cfg_inch), 16'(inch));
    do_step("f_done", SG_F, 3'd2, 9'd0, min_cnt(outch, 0));
    if (strays) do_step("stray_f", SG_F, 3'd2, 9'd0, min_cnt(outch, 0));
    do_step("b_done", SG_B, 3'd3, 9'd0, min_cnt(outch, 0));
    forever begin
      do_step("w_done", SG_W, 3'd4, 9'(base), min_cnt(outch, base));
      if (strays && pass == 1) begin
        do_step("stray_start", SG_START, 3'd4, 9'(base), min_cnt(outch, base));
        do_step("stray_send", SG_SEND, 3'd4, 9'(base), min_cnt(outch, base));
      end
      if (pass == abort_pass) begin
        do_step("abort", SG_ABORT, 3'd0, 9'(base), min_cnt(outch, base));
        chk("abort_err", 16'(conv_err), 16'd1);
        chk("abort_done", 16'(conv_done), 16'd0);
        return;
      end
      do_step("rdy", SG_RDY, 3'd5, 9'(base), min_cnt(outch, base));
      if (pass == rst_pass) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("mid_rst");
        do_step("post_rst_rdy", SG_RDY, 3'd0, 9'd0, 9'd0);
        do_step("post_rst_send", SG_SEND, 3'd0, 9'd0, 9'd0);
        check_reset_values("post_rst");
        return;
      end
      if (base + P < outch) begin
        base += P;
        do_step("send_next", SG_SEND, 3'd3, 9'(base), min_cnt(outch, base));
        pass++;
      end else begin
        do_step("send_last", SG_SEND, 3'd0, 9'd0, 9'd0);
        chk("last_pass_idx", 16'(pass), 16'((outch + P - 1) / P));
        chk("done_not_yet", 16'(conv_done), 16'd0);
        @(negedge clk);
        chk("layer_done", 16'(conv_done), 16'd1);
        chk("layer_err", 16'(conv_err), 16'd0);
        chk("layer_cmd_idle", 16'(command), 16'd0);
        $display("layer outch=%0d passes=%0d done=%0d err=%0d", outch, pass, conv_done, conv_err);
        return;
      end
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("idle");

    layer(8, 3, 20, 1'b0, 0, 0);
    layer(8, 3, 16, 1'b0, 0, 0);

    // Bad configuration: no command, error and done flagged, busy stays low.
    Flen = 6'd8; num_INCH = 9'd0; num_OUTCH = 9'd20;
    do_step("bad_start", SG_START, 3'd0, 9'd0, 9'd0);
    chk("bad_err", 16'(conv_err), 16'd1);
    @(negedge clk);
    chk("bad_done", 16'(conv_done), 16'd1);
    chk("bad_cmd", 16'(command), 16'd0);
    chk("bad_busy", 16'(busy), 16'd0);
    @(negedge clk);

    layer(8, 3, 20, 1'b1, 0, 0);

    // Abort during pass 2, then a clean layer.
    layer(5, 4, 20, 1'b0, 2, 0);
    @(negedge clk);
    chk("post_abort_cmd", 16'(command), 16'd0);
    layer(5, 4, 9, 1'b0, 0, 0);

    // Abort while idle blocks a same-cycle start.
    abort = 1'b1;
    do_step("abort_idle", SG_START, 3'd0, 9'd0, 9'd0);
    abort = 1'b0;
    chk("abort_idle_done_kept", 16'(conv_done), 16'd1);

    layer(8, 3, 20, 1'b0, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
